// File: rtl/dp_seq_pkg.sv
// Shared types and decode helpers for the top_DP sequencer.
// Optional WAIT watchdog is enabled by defining DP_SEQ_TIMEOUT_EN.
package dp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    U_CALC = 2'd0,
    U_DIV  = 2'd1,
    U_MULT = 2'd2,
    U_ILL  = 2'd3
  } unit_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_MULT = 3'b101;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_CALC = 2'b01;
  localparam logic [1:0] SEL_MULT = 2'b10;
  localparam logic [1:0] SEL_DIV  = 2'b11;

  function automatic unit_t unit_of(input logic [2:0] op);
    unit_t u;
    case (op)
      OP_ADD, OP_SUB,
      OP_AND, OP_XOR: u = U_CALC;
      OP_DIV:         u = U_DIV;
      OP_MULT:        u = U_MULT;
      default:        u = U_ILL;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/dp_seq_wdog.sv
// WAIT-cycle watchdog for dp_seq_ctrl (used under DP_SEQ_TIMEOUT_EN).
// expire_o is high during the LIMIT-th enabled cycle after a clear.
module dp_seq_wdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/dp_seq_ctrl.sv
// Moore sequencer driving the top_DP control word for one command.
// Define DP_SEQ_TIMEOUT_EN to abort a stuck WAIT after TIMEOUT_CYCLES.
module dp_seq_ctrl
  import dp_seq_pkg::*;
#(
  parameter int OPW            = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [OPW-1:0] op,
  input  logic           done_calc,
  input  logic           done_div,
  input  logic           done_mult,
  output logic           en_x,
  output logic           en_y,
  output logic           go_calc,
  output logic           go_div,
  output logic           go_mult,
  output logic [1:0]     op_calc,
  output logic           sel_h,
  output logic [1:0]     sel_l,
  output logic           en_out_h,
  output logic           en_out_l,
  output logic           busy,
  output logic           done,
  output logic           err
);

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       err_q, err_d;
  unit_t      unit;
  logic       unit_done;
  logic       tmo_hit;

  assign unit = unit_of(op_q);

  always_comb begin
    unit_done = 1'b0;
    case (unit)
      U_CALC:  unit_done = done_calc;
      U_DIV:   unit_done = done_div;
      U_MULT:  unit_done = done_mult;
      default: unit_done = 1'b0;
    endcase
  end

`ifdef DP_SEQ_TIMEOUT_EN
  logic wdog_expire;

  dp_seq_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == ST_START),
    .en_i     (state_q == ST_WAIT),
    .expire_o (wdog_expire)
  );

  assign tmo_hit = wdog_expire;
`else
  // Constant false; WAIT never aborts without the watchdog.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          if (unit_of(op[2:0]) == U_ILL) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            op_d    = op[2:0];
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (unit_done) begin
          state_d = ST_OUT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_OUT:   state_d = ST_DONE;
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  logic in_sel;
  logic in_calc;

  assign in_sel  = (state_q == ST_WAIT) || (state_q == ST_OUT);
  assign in_calc = in_sel || (state_q == ST_START);

  always_comb begin
    en_x     = (state_q == ST_LOAD);
    en_y     = (state_q == ST_LOAD);
    go_calc  = 1'b0;
    go_div   = 1'b0;
    go_mult  = 1'b0;
    op_calc  = 2'b00;
    sel_h    = 1'b0;
    sel_l    = SEL_NONE;
    en_out_h = 1'b0;
    en_out_l = 1'b0;
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    err      = (state_q == ST_DONE) && err_q;
    if (state_q == ST_START) begin
      go_calc = (unit == U_CALC);
      go_div  = (unit == U_DIV);
      go_mult = (unit == U_MULT);
    end
    if (in_calc && unit == U_CALC)
      op_calc = op_q[1:0];
    // Mux selects settle in WAIT so OUT only flips the enables.
    if (in_sel) begin
      case (unit)
        U_CALC:  sel_l = SEL_CALC;
        U_DIV: begin
          sel_l = SEL_DIV;
          sel_h = 1'b1;
        end
        U_MULT:  sel_l = SEL_MULT;
        default: sel_l = SEL_NONE;
      endcase
    end
    if (state_q == ST_OUT) begin
      en_out_l = 1'b1;
      en_out_h = (unit != U_CALC);
    end
  end

endmodule

// File: doc/dp_seq_ctrl.md
Name: dp_seq_ctrl

Overview:
- Control unit that sequences the top_DP arithmetic datapath: add, sub, and, xor, div and mult.
- Accepts a one-cycle command (`go` + `op`) and drives the datapath control word:
  - operand load
  - unit start strobe
  - output mux selects
  - output register enables
- Waits on the selected unit's done flag, then pulses `done` to the requester.
- Sits beside top_DP; together they replace bench-driven control words.

Parameters:
- OPW, 3, width of command opcode.
- TIMEOUT_CYCLES, 16, maximum WAIT cycles before abort (used only with DP_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  command strobe, sampled only in IDLE.
- op  in  OPW  000 add, 001 sub, 010 and, 011 xor, 100 div, 101 mult, 11x illegal.
- done_calc  in  1  calc unit complete.
- done_div  in  1  divider complete.
- done_mult  in  1  multiplier complete.
- en_x  out  1  load x register.
- en_y  out  1  load y register.
- go_calc  out  1  calc unit start.
- go_div  out  1  divider start.
- go_mult  out  1  multiplier start.
- op_calc  out  2  calc operation.
- sel_h  out  1  high output mux select.
- sel_l  out  2  low output mux select.
- en_out_h  out  1  high output register enable.
- en_out_l  out  1  low output register enable.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  error flag; valid while done=1.

Behaviour:
- Outputs are Moore: decoded only from registered state and latched op_r.
- Reset (async):
  - state=IDLE, op_r=0.
  - All outputs 0 immediately, including mid-operation; any in-flight command is discarded.
- IDLE:
  - busy=0.
  - go=1 with legal op: latch op_r, go to LOAD.
  - go=1 with illegal op: latch err, go to DONE.
  - go=0: stay.
- LOAD (1 cycle): en_x=en_y=1 → START.
- START (1 cycle): assert exactly one strobe → WAIT.
  - go_calc for op_r 0xx.
  - go_div for 100.
  - go_mult for 101.
- WAIT:
  - All start strobes 0.
  - Stay until the selected unit's done_* = 1, then → OUT.
  - done_* of unselected units are ignored.
  - done_* already high in the first WAIT cycle is accepted.
- OUT (1 cycle) → DONE.
  - calc: sel_l=01, sel_h=0, en_out_l=1, en_out_h=0.
  - div: sel_l=11, sel_h=1, en_out_l=1, en_out_h=1.
  - mult: sel_l=10, sel_h=0, en_out_l=1, en_out_h=1.
- DONE (1 cycle): done=1, err per command → IDLE. err clears on leaving DONE.
- Select and op_calc timing:
  - op_calc = op_r[1:0] from START through OUT for calc ops; 00 otherwise.
  - sel_h and sel_l take their OUT values from WAIT through OUT, so the mux is settled before the enable.
  - All selects are 00/0 in IDLE, LOAD and START.
- busy=1 in every state except IDLE.
- go while busy is ignored; no queueing.
- Latency: go sampled at edge E0 → LOAD after E0, START after E1, WAIT after E2. If done_* is high in the first WAIT cycle: OUT after E3, done high after E4.
- Minimum go→done is 5 cycles; each extra WAIT cycle adds 1.
- Back-to-back: go may be high in the cycle after DONE (state is IDLE).

Optional Feature:
- Macro: DP_SEQ_TIMEOUT_EN.
- Defined:
  - WAIT cycle counter, cleared on entering WAIT.
  - If TIMEOUT_CYCLES WAIT cycles elapse without the selected done_*, go to DONE with err=1, skipping OUT.
  - Output registers are never enabled on timeout.
- Undefined:
  - No counter; WAIT holds indefinitely.
  - err is set only by an illegal op.

Decomposition:
- Package dp_seq_pkg:
  - State enum: IDLE, LOAD, START, WAIT, OUT, DONE.
  - Opcode constants.
  - sel_l encodings: CALC=01, MULT=10, DIV=11.
  - Unit-class decode function (op → calc/div/mult).
- Sub-module dp_seq_wdog: WAIT-cycle counter with clear/enable/expire. Instantiated only under DP_SEQ_TIMEOUT_EN.

Test Plan:
- Reset mid-WAIT (div in progress), assert rst → all outputs 0 within the same cycle; state IDLE; next go=1, op=000 completes normally.
- op=000 (add), x=1110, y=0011 with top_DP attached → done 5 cycles after go; en_out_l only; out_l=0001, err=0.
- op=100 (div), done_div delayed 7 cycles → done 11 cycles after go; en_out_h=en_out_l=1; sel_h=1, sel_l=11 during OUT; go_div high exactly 1 cycle.
- op=110 → done next cycle with err=1; no en_x, no start strobes, no output enables.
- go held high through an op=101 command → exactly one command executes; a second starts only when go is still high in IDLE after DONE. done_calc pulses during the mult WAIT are ignored.
- DP_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, op=101, done_mult never asserted → done with err=1 after the 16th WAIT cycle; en_out_h and en_out_l never high.
